// File: rtl/spi_reg_pkg.sv
// ---------------------------------------------------------------------------
// spi_reg_pkg: shared constants, FSM state type and frame builder for spi_reg_master.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_reg_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam int         FRAME_BITS = 24;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic       wr,
        input logic [7:0] addr,
        input logic [7:0] wdata
    );
        return wr ? {CMD_WRITE, addr, wdata} : {CMD_READ, addr, 8'h00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_reg_master_half_tick.sv
// ---------------------------------------------------------------------------
// spi_half_tick: loadable down-counter giving a one-cycle tick every CLK_DIV cycles.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_half_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tick
);

    localparam int           W      = $clog2(CLK_DIV) + 1;
    localparam logic [W-1:0] RELOAD = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == '0);

    // Reloading on every tick keeps each phase exactly CLK_DIV cycles long.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RELOAD;
        end else if (load || tick) begin
            cnt <= RELOAD;
        end else if (en) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_reg_master.sv
// ---------------------------------------------------------------------------
// spi_reg_master: SPI mode-0 master issuing one 3-byte register access per request.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_reg_master
    import spi_reg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_req,
    input  logic       i_wr,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic       o_spi_sclk,
    output logic       o_spi_cs_n,
    output logic       o_spi_mosi,
    input  logic       i_spi_miso
);

    state_t                  state;
    state_t                  next_state;
    logic                    tick;
    logic                    accept;
    logic                    rise;
    logic                    fall;
    logic                    finish;
    logic                    sclk;
    logic                    is_read;
    logic                    done;
    logic [4:0]              bit_cnt;
    logic [FRAME_BITS-1:0]   tx;
    logic [7:0]              rx;
    logic [7:0]              rdata;

    spi_half_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_half_tick (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .load  (accept),
        .en    (state != IDLE),
        .tick  (tick)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        rise       = 1'b0;
        fall       = 1'b0;
        case (state)
            IDLE: begin
                if (i_req) begin
                    accept     = 1'b1;
                    next_state = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    rise       = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                // High half ends with a falling edge; low half either starts the next bit or exits.
                if (tick) begin
                    if (sclk) begin
                        fall = 1'b1;
                    end else if (bit_cnt == 5'd0) begin
                        next_state = HOLD;
                    end else begin
                        rise = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    next_state = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign finish = (state == GAP) && tick;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sclk    <= 1'b0;
            tx      <= '0;
            rx      <= '0;
            bit_cnt <= '0;
            is_read <= 1'b0;
            done    <= 1'b0;
            rdata   <= '0;
        end else begin
            done <= finish;
            if (accept) begin
                tx      <= build_frame(i_wr, i_addr, i_wdata);
                bit_cnt <= 5'(FRAME_BITS - 1);
                is_read <= ~i_wr;
            end
            // After 24 samples rx holds exactly the data byte; earlier bytes fall off the top.
            if (rise) begin
                sclk <= 1'b1;
                rx   <= {rx[6:0], i_spi_miso};
                if (state == SHIFT) begin
                    bit_cnt <= bit_cnt - 5'd1;
                end
            end
            if (fall) begin
                sclk <= 1'b0;
                tx   <= {tx[FRAME_BITS-2:0], 1'b0};
            end
            if (finish && is_read) begin
                rdata <= rx;
            end
        end
    end

    assign o_busy     = (state != IDLE);
    assign o_done     = done;
    assign o_rdata    = rdata;
    assign o_spi_sclk = sclk;
    assign o_spi_cs_n = (state == IDLE) || (state == GAP);
    assign o_spi_mosi = tx[FRAME_BITS-1];

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_master.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_master: self-checking bench with an SPI register-slave model and reference register map.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_reg_master;

    localparam int CLK_DIV = 4;
    localparam int CS_LOW  = 50 * CLK_DIV;
    localparam int DONE_AT = 50 * CLK_DIV + CLK_DIV + 1;

    logic       clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_req = 1'b0;
    logic       i_wr = 1'b0;
    logic [7:0] i_addr = 8'h00;
    logic [7:0] i_wdata = 8'h00;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_rdata;
    logic       o_spi_sclk;
    logic       o_spi_cs_n;
    logic       o_spi_mosi;
    logic       i_spi_miso = 1'b0;

    int total = 0;
    int bad   = 0;

    spi_reg_master #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (i_reset_n),
        .i_req      (i_req),
        .i_wr       (i_wr),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_rdata    (o_rdata),
        .o_spi_sclk (o_spi_sclk),
        .o_spi_cs_n (o_spi_cs_n),
        .o_spi_mosi (o_spi_mosi),
        .i_spi_miso (i_spi_miso)
    );

    always #5 clk = ~clk;

    // Remote register block and the bench's expectation of its contents.
    logic [7:0] slv_regs [256] = '{1: 8'h55, 2: 8'hAA, 3: 8'h3C, default: 8'h00};
    logic [7:0] ref_regs [256] = '{1: 8'h55, 2: 8'hAA, 3: 8'h3C, default: 8'h00};

    int          sbit = 0;
    logic [23:0] sframe = '0;
    logic [7:0]  saddr = '0;
    logic [23:0] last_frame = '0;
    int          last_bits = 0;

    always @(posedge o_spi_sclk, posedge o_spi_cs_n) begin
        if (o_spi_cs_n) begin
            last_frame = sframe;
            last_bits  = sbit;
            if (sbit == 24 && sframe[23:16] == 8'h02) slv_regs[sframe[15:8]] = sframe[7:0];
            sbit   = 0;
            sframe = '0;
        end else begin
            sframe = {sframe[22:0], o_spi_mosi};
            sbit++;
            if (sbit == 16) saddr = sframe[7:0];
        end
    end

    // Command/address phases return noise; the data phase returns the addressed register.
    always @(negedge o_spi_cs_n, negedge o_spi_sclk) begin
        if (!o_spi_cs_n) begin
            if (sbit >= 16 && sbit < 24) i_spi_miso = slv_regs[saddr][23 - sbit];
            else i_spi_miso = 1'($urandom_range(0, 1));
        end
    end

    int cyc = 0;
    int sclk_rises = 0;
    int accept_cnt = 0;
    int last_accept = 0;
    int done_cnt = 0;
    int last_done = 0;
    int done_long = 0;
    bit done_prev = 1'b0;
    int cs_low_run = 0;
    int cs_high_run = 0;
    int last_cs_low = 0;
    int last_cs_high = 0;

    always @(posedge clk) cyc++;
    always @(posedge o_spi_sclk) sclk_rises++;

    // Observed cycle index p corresponds to spec cycle p+1; acceptance edge T = p+1 of the request cycle.
    always @(negedge clk) begin
        if (i_reset_n) begin
            if (i_req && !o_busy) begin
                accept_cnt++;
                last_accept = cyc + 1;
            end
            if (o_done) begin
                done_cnt++;
                last_done = cyc;
                if (done_prev) done_long++;
            end
            done_prev = o_done;
            if (!o_spi_cs_n) begin
                if (cs_high_run > 0) last_cs_high = cs_high_run;
                cs_high_run = 0;
                cs_low_run++;
            end else begin
                if (cs_low_run > 0) last_cs_low = cs_low_run;
                cs_low_run = 0;
                cs_high_run++;
            end
        end else begin
            cs_low_run  = 0;
            cs_high_run = 0;
            done_prev   = 1'b0;
        end
    end

    task automatic do_access(input logic wr, input logic [7:0] a, input logic [7:0] d,
                             output int t_acc, output int t_done);
        int d0 = done_cnt;
        @(posedge clk); #1;
        i_req = 1'b1; i_wr = wr; i_addr = a; i_wdata = d;
        @(posedge clk); #1;
        i_req = 1'b0;
        t_acc = last_accept;
        for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge clk);
        total++;
        if (done_cnt == d0) begin
            bad++;
            $display("FAIL access_timeout: done_cnt=%0d required>%0d", done_cnt, d0);
        end
        t_done = last_done;
        if (wr) ref_regs[a] = d;
    endtask

    task automatic test_reset();
        int r0;
        i_reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 i_reset_n = 1'b1;
        r0 = sclk_rises;
        repeat (20) @(negedge clk);
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", o_done); end
        total++; if (o_rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h want 00", o_rdata); end
        total++; if (o_spi_sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk: got %b want 0", o_spi_sclk); end
        total++; if (o_spi_cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n: got %b want 1", o_spi_cs_n); end
        total++; if (o_spi_mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi: got %b want 0", o_spi_mosi); end
        total++; if (sclk_rises != r0) begin bad++; $display("FAIL reset_sclk_idle: got %0d edges want 0", sclk_rises - r0); end
    endtask

    task automatic test_write();
        int ta, td;
        do_access(1'b1, 8'h00, 8'hA5, ta, td);
        total++; if (last_frame !== 24'h0200A5 || last_bits != 24) begin
            bad++; $display("FAIL write_frame: got %h/%0d bits want 0200a5/24", last_frame, last_bits); end
        total++; if (last_cs_low != CS_LOW) begin bad++; $display("FAIL write_cs_low: got %0d want %0d", last_cs_low, CS_LOW); end
        total++; if (td + 1 - ta != DONE_AT) begin bad++; $display("FAIL write_done_time: got T+%0d want T+%0d", td + 1 - ta, DONE_AT); end
        total++; if (o_rdata !== 8'h00) begin bad++; $display("FAIL write_rdata: got %h want 00", o_rdata); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL write_busy_end: got %b want 0", o_busy); end
    endtask

    task automatic test_read_reset_values();
        logic [7:0] addrs [3] = '{8'h01, 8'h03, 8'h02};
        int ta, td;
        foreach (addrs[k]) begin
            do_access(1'b0, addrs[k], 8'($urandom), ta, td);
            total++; if (o_rdata !== ref_regs[addrs[k]]) begin
                bad++; $display("FAIL read_%h: got %h want %h", addrs[k], o_rdata, ref_regs[addrs[k]]); end
            total++; if (last_frame !== {8'h03, addrs[k], 8'h00}) begin
                bad++; $display("FAIL read_frame_%h: got %h want %h", addrs[k], last_frame, {8'h03, addrs[k], 8'h00}); end
        end
    endtask

    task automatic test_random();
        logic [7:0] a, d, b, prev;
        int ta, td;
        for (int n = 0; n < 6; n++) begin
            a = 8'($urandom);
            d = 8'($urandom);
            prev = o_rdata;
            do_access(1'b1, a, d, ta, td);
            total++; if (last_frame !== {8'h02, a, d}) begin
                bad++; $display("FAIL rand_wframe: got %h want %h", last_frame, {8'h02, a, d}); end
            total++; if (o_rdata !== prev) begin bad++; $display("FAIL rand_write_rdata: got %h want %h", o_rdata, prev); end
            b = ($urandom_range(0, 1) == 1) ? a : 8'($urandom);
            do_access(1'b0, b, 8'($urandom), ta, td);
            total++; if (o_rdata !== ref_regs[b]) begin
                bad++; $display("FAIL rand_read_%h: got %h want %h", b, o_rdata, ref_regs[b]); end
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        int a0 = accept_cnt;
        int first_done;
        @(posedge clk); #1;
        i_req = 1'b1; i_wr = 1'b1; i_addr = 8'h02; i_wdata = 8'h7E;
        @(posedge clk); #1;
        i_wr = 1'b0;
        ref_regs[8'h02] = 8'h7E;
        for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge clk);
        @(posedge clk); #1;
        i_req = 1'b0;
        first_done = last_done;
        total++; if (last_accept != first_done + 1) begin
            bad++; $display("FAIL b2b_accept: got T=%0d want %0d", last_accept, first_done + 1); end
        for (int i = 0; i < 400 && done_cnt < d0 + 2; i++) @(negedge clk);
        total++; if (done_cnt != d0 + 2) begin bad++; $display("FAIL b2b_done_count: got %0d want %0d", done_cnt - d0, 2); end
        total++; if (accept_cnt != a0 + 2) begin bad++; $display("FAIL b2b_accept_count: got %0d want 2", accept_cnt - a0); end
        // Deselect spans the GAP phase plus the one idle done cycle.
        total++; if (last_cs_high != CLK_DIV + 1) begin
            bad++; $display("FAIL b2b_cs_high: got %0d want %0d", last_cs_high, CLK_DIV + 1); end
        total++; if (o_rdata !== 8'h7E) begin bad++; $display("FAIL b2b_rdata: got %h want 7e", o_rdata); end
    endtask

    task automatic test_req_ignored();
        int d0 = done_cnt;
        int a0 = accept_cnt;
        @(posedge clk); #1;
        i_req = 1'b1; i_wr = 1'b0; i_addr = 8'h03;
        @(posedge clk); #1;
        i_req = 1'b0;
        repeat (48) @(posedge clk);
        #1 i_req = 1'b1; i_addr = 8'h01;
        @(posedge clk); #1;
        i_req = 1'b0;
        repeat (300) @(negedge clk);
        total++; if (done_cnt != d0 + 1) begin bad++; $display("FAIL ignore_done: got %0d pulses want 1", done_cnt - d0); end
        total++; if (accept_cnt != a0 + 1) begin bad++; $display("FAIL ignore_accept: got %0d want 1", accept_cnt - a0); end
        total++; if (o_rdata !== ref_regs[8'h03]) begin bad++; $display("FAIL ignore_rdata: got %h want %h", o_rdata, ref_regs[8'h03]); end
    endtask

    task automatic test_reset_mid_frame();
        int d0 = done_cnt;
        int r0;
        int ta, td;
        @(posedge clk); #1;
        i_req = 1'b1; i_wr = 1'b0; i_addr = 8'h03;
        r0 = sclk_rises;
        @(posedge clk); #1;
        i_req = 1'b0;
        // Bit 10 is the 14th bit shifted; stop in its high half.
        for (int i = 0; i < 300 && sclk_rises - r0 < 14; i++) @(negedge clk);
        total++; if (sclk_rises - r0 != 14) begin bad++; $display("FAIL abort_reach_bit: got %0d rises want 14", sclk_rises - r0); end
        #2 i_reset_n = 1'b0;
        #1;
        total++; if (o_spi_cs_n !== 1'b1) begin bad++; $display("FAIL abort_cs_n: got %b want 1", o_spi_cs_n); end
        total++; if (o_spi_sclk !== 1'b0) begin bad++; $display("FAIL abort_sclk: got %b want 0", o_spi_sclk); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", o_busy); end
        repeat (3) @(negedge clk);
        i_reset_n = 1'b1;
        repeat (10) @(negedge clk);
        total++; if (done_cnt != d0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - d0); end
        do_access(1'b0, 8'h03, 8'h00, ta, td);
        total++; if (o_rdata !== 8'h3C) begin bad++; $display("FAIL abort_reread: got %h want 3c", o_rdata); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read_reset_values();
        test_random();
        test_back_to_back();
        test_req_ignored();
        test_reset_mid_frame();
        total++; if (done_long != 0) begin bad++; $display("FAIL done_width: got %0d long pulses want 0", done_long); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
